// File: rtl/char_window_addr_gen.sv
// Raster-timed write-address generator for NUM_CH character capture windows.
// Frame-boundary actions happen on the edge that wraps the counters into (0,0).
module char_window_addr_gen #(
    parameter int H_REZ  = 640,
    parameter int H_MAX  = 800,
    parameter int V_REZ  = 480,
    parameter int V_MAX  = 525,
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*10-1:0]     win_x,
    input  logic [NUM_CH*10-1:0]     win_y,
    input  logic [NUM_CH*10-1:0]     win_w,
    input  logic [NUM_CH*10-1:0]     win_h,
    input  logic                     single_shot,
    input  logic                     arm,
    output logic [9:0]               h_count,
    output logic [9:0]               v_count,
    output logic [NUM_CH*ADDR_W-1:0] ram_addr,
    output logic [NUM_CH-1:0]        we,
    output logic                     frame_start,
    output logic                     frame_done,
    output logic                     busy,
    output logic [NUM_CH-1:0]        overflow
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_CAPT  = 2'd2;

    localparam logic [9:0]  H_LAST = 10'(H_MAX - 1);
    localparam logic [9:0]  V_LAST = 10'(V_MAX - 1);
    localparam logic [9:0]  V_PRE  = 10'(V_REZ - 1);
    localparam logic [10:0] H_ACT  = 11'(H_REZ);
    localparam logic [10:0] V_ACT  = 11'(V_REZ);

    logic [9:0]           h_q, h_d, v_q, v_d;
    logic [1:0]           state_q, state_d;
    logic [NUM_CH*10-1:0] sx_q, sy_q, sw_q, sh_q;
    logic                 ss_q;
    logic                 fs_q, fd_q;
    logic                 h_end, frame_wrap, done_edge, capt;

    assign h_end      = (h_q == H_LAST);
    assign frame_wrap = h_end && (v_q == V_LAST);
    // next count will be (0, V_REZ): end of the active area
    assign done_edge  = h_end && (v_q == V_PRE);
    assign capt       = (state_q == ST_CAPT);

    always_comb begin
        h_d = h_end ? 10'd0 : h_q + 10'd1;
        v_d = v_q;
        if (h_end) v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
    end

    always_comb begin
        state_d = state_q;
        if (frame_wrap) begin
            if (!single_shot || state_q == ST_ARMED) state_d = ST_CAPT;
            else if (state_q == ST_IDLE && arm)     state_d = ST_ARMED;
            else                                    state_d = ST_IDLE;
        end else if (done_edge && capt && ss_q) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_IDLE && arm) begin
            state_d = ST_ARMED;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q     <= '0;
            v_q     <= '0;
            state_q <= ST_IDLE;
            sx_q    <= '0;
            sy_q    <= '0;
            sw_q    <= '0;
            sh_q    <= '0;
            ss_q    <= 1'b0;
            fs_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            state_q <= state_d;
            fs_q    <= frame_wrap;
            fd_q    <= done_edge && capt;
            if (frame_wrap) begin
                sx_q <= win_x;
                sy_q <= win_y;
                sw_q <= win_w;
                sh_q <= win_h;
                ss_q <= single_shot;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [10:0]       x11, y11, w11, ht11, hc11, vc11;
        logic              hit;
        logic [ADDR_W:0]   cnt_q;
        logic [ADDR_W-1:0] addr_q;
        logic              we_q, ovf_q;

        assign x11  = {1'b0, sx_q[c*10 +: 10]};
        assign y11  = {1'b0, sy_q[c*10 +: 10]};
        assign w11  = {1'b0, sw_q[c*10 +: 10]};
        assign ht11 = {1'b0, sh_q[c*10 +: 10]};
        assign hc11 = {1'b0, h_q};
        assign vc11 = {1'b0, v_q};

        // 11-bit sums so a window running past 1023 never wraps back in
        assign hit = capt && (w11 != 11'd0) && (ht11 != 11'd0)
                   && (hc11 >= x11) && (hc11 < x11 + w11) && (hc11 < H_ACT)
                   && (vc11 >= y11) && (vc11 < y11 + ht11) && (vc11 < V_ACT);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                addr_q <= '0;
                we_q   <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                we_q <= 1'b0;
                if (frame_wrap) begin
                    cnt_q  <= '0;
                    addr_q <= '0;
                end else if (hit) begin
                    // cnt_q MSB set means the RAM is full for this frame
                    if (!cnt_q[ADDR_W]) begin
                        we_q   <= 1'b1;
                        addr_q <= cnt_q[ADDR_W-1:0];
                        cnt_q  <= cnt_q + 1'b1;
                    end else begin
                        ovf_q  <= 1'b1;
                    end
                end
            end
        end

        assign ram_addr[c*ADDR_W +: ADDR_W] = addr_q;
        assign we[c]       = we_q;
        assign overflow[c] = ovf_q;
    end

    assign h_count     = h_q;
    assign v_count     = v_q;
    assign frame_start = fs_q;
    assign frame_done  = fd_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_char_window_addr_gen.sv
// Randomized bench for char_window_addr_gen on a shrunken raster; expectations come
// from a per-pixel closed-form model (address = row-major index in the clipped window).
module tb_char_window_addr_gen;

    localparam int H_REZ  = 40;
    localparam int H_MAX  = 48;
    localparam int V_REZ  = 24;
    localparam int V_MAX  = 28;
    localparam int NUM_CH = 4;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int FRAME  = H_MAX * V_MAX;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_CH*10-1:0]     win_x, win_y, win_w, win_h;
    logic                     single_shot, arm;
    logic [9:0]               h_count, v_count;
    logic [NUM_CH*ADDR_W-1:0] ram_addr;
    logic [NUM_CH-1:0]        we, overflow;
    logic                     frame_start, frame_done, busy;

    char_window_addr_gen #(
        .H_REZ(H_REZ), .H_MAX(H_MAX), .V_REZ(V_REZ), .V_MAX(V_MAX),
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .win_x(win_x), .win_y(win_y), .win_w(win_w), .win_h(win_h),
        .single_shot(single_shot), .arm(arm),
        .h_count(h_count), .v_count(v_count),
        .ram_addr(ram_addr), .we(we),
        .frame_start(frame_start), .frame_done(frame_done),
        .busy(busy), .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int  mh, mv;
    int  gx[NUM_CH], gy[NUM_CH], gw[NUM_CH], gh[NUM_CH];
    bit  m_ss, m_cap, m_arm;
    logic [NUM_CH-1:0]             e_we, e_ovf;
    logic [NUM_CH-1:0][ADDR_W-1:0] e_addr;
    logic                          e_fs, e_fd;

    // observation counters for directed frame-level checks
    int cnt_we[NUM_CH];
    int cnt_fd, first_h, first_v;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit in_win(int c, int h, int v);
        return gw[c] > 0 && gh[c] > 0 && h >= gx[c] && h < gx[c] + gw[c] && h < H_REZ
            && v >= gy[c] && v < gy[c] + gh[c] && v < V_REZ;
    endfunction

    task automatic model_edge();
        int nh, nv, idx, right;
        e_we = '0;
        e_fs = 1'b0;
        e_fd = 1'b0;
        if (!rst_n) begin
            mh = 0; mv = 0; m_ss = 0; m_cap = 0; m_arm = 0;
            e_addr = '0; e_ovf = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                gx[c] = 0; gy[c] = 0; gw[c] = 0; gh[c] = 0;
            end
            return;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (m_cap && in_win(c, mh, mv)) begin
                right = (gx[c] + gw[c] > H_REZ) ? H_REZ : gx[c] + gw[c];
                idx = (mv - gy[c]) * (right - gx[c]) + (mh - gx[c]);
                if (idx < DEPTH) begin
                    e_we[c]   = 1'b1;
                    e_addr[c] = ADDR_W'(idx);
                end else begin
                    e_ovf[c]  = 1'b1;
                    e_addr[c] = ADDR_W'(DEPTH - 1);
                end
            end
        end
        nh = mh + 1;
        nv = mv;
        if (nh == H_MAX) begin
            nh = 0;
            nv = (mv + 1 == V_MAX) ? 0 : mv + 1;
        end
        e_fs = (nh == 0 && nv == 0);
        e_fd = (nh == 0 && nv == V_REZ && m_cap);
        if (e_fs) begin
            for (int c = 0; c < NUM_CH; c++) begin
                gx[c] = int'(win_x[c*10 +: 10]);
                gy[c] = int'(win_y[c*10 +: 10]);
                gw[c] = int'(win_w[c*10 +: 10]);
                gh[c] = int'(win_h[c*10 +: 10]);
            end
            m_ss = single_shot;
            e_addr = '0;
            if (!single_shot || m_arm) begin
                m_cap = 1; m_arm = 0;
            end else begin
                m_arm = arm && !m_cap;
                m_cap = 0;
            end
        end else if (e_fd && m_ss) begin
            m_cap = 0;
        end else if (!m_cap && !m_arm && arm) begin
            m_arm = 1;
        end
        mh = nh;
        mv = nv;
    endtask

    task automatic compare_all();
        chk("h_count",     64'(h_count),     64'(mh));
        chk("v_count",     64'(v_count),     64'(mv));
        chk("we",          64'(we),          64'(e_we));
        chk("ram_addr",    64'(ram_addr),    64'(e_addr));
        chk("overflow",    64'(overflow),    64'(e_ovf));
        chk("busy",        64'(busy),        64'(m_cap || m_arm));
        chk("frame_start", 64'(frame_start), 64'(e_fs));
        chk("frame_done",  64'(frame_done),  64'(e_fd));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        for (int c = 0; c < NUM_CH; c++) begin
            if (we[c] === 1'b1) begin
                cnt_we[c]++;
                if (c == 0 && first_h < 0) begin
                    first_h = int'(h_count);
                    first_v = int'(v_count);
                end
            end
        end
        if (frame_done === 1'b1) cnt_fd++;
    endtask

    task automatic set_win(input int c, input int x, input int y, input int w, input int h);
        win_x[c*10 +: 10] = 10'(x);
        win_y[c*10 +: 10] = 10'(y);
        win_w[c*10 +: 10] = 10'(w);
        win_h[c*10 +: 10] = 10'(h);
    endtask

    task automatic rand_win(input int c);
        set_win(c, $urandom_range(0, H_REZ + 4), $urandom_range(0, V_REZ + 4),
                $urandom_range(0, 12), $urandom_range(0, 8));
    endtask

    task automatic run(input int n, input int arm_rate, input int chg_rate);
        cnt_fd = 0; first_h = -1; first_v = -1;
        for (int c = 0; c < NUM_CH; c++) cnt_we[c] = 0;
        for (int i = 0; i < n; i++) begin
            arm = (arm_rate > 0) && ($urandom_range(0, arm_rate - 1) == 0);
            if (chg_rate > 0 && $urandom_range(0, chg_rate - 1) == 0)
                rand_win($urandom_range(0, NUM_CH - 1));
            step();
        end
        arm = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        win_x = '0; win_y = '0; win_w = '0; win_h = '0;
        single_shot = 1'b0;
        arm = 1'b0;
        cnt_fd = 0; first_h = -1; first_v = -1;
        @(negedge clk);
        step();
        step();
        chk("reset_we",   64'(we),       64'd0);
        chk("reset_busy", 64'(busy),     64'd0);
        chk("reset_addr", 64'(ram_addr), 64'd0);

        // basic window, continuous
        set_win(0, 10, 5, 4, 2);
        rst_n = 1'b1;
        run(FRAME, 0, 0);
        run(FRAME, 0, 0);
        chk("basic_writes", 64'(cnt_we[0]), 64'd8);
        chk("basic_first_h", 64'(first_h), 64'd11);
        chk("basic_first_v", 64'(first_v), 64'd5);
        chk("basic_done", 64'(cnt_fd), 64'd1);

        // window clipped at the bottom-right corner
        set_win(1, H_REZ - 2, V_REZ - 2, 10, 5);
        run(FRAME, 0, 0);
        run(FRAME, 0, 0);
        chk("clip_writes", 64'(cnt_we[1]), 64'd4);
        chk("clip_ovf", 64'(overflow[1]), 64'd0);

        // 8x6 window into a 32-entry RAM
        set_win(2, 20, 8, 8, 6);
        run(FRAME, 0, 0);
        run(FRAME, 0, 0);
        chk("ovf_writes", 64'(cnt_we[2]), 64'(DEPTH));
        chk("ovf_flag", 64'(overflow[2]), 64'd1);
        run(FRAME, 0, 0);
        chk("ovf_sticky", 64'(overflow[2]), 64'd1);

        // random mid-frame geometry changes, then a disabled channel
        run(3 * FRAME, 0, 150);
        set_win(3, 5, 5, 0, 6);
        run(FRAME, 0, 0);
        run(FRAME, 0, 0);
        chk("disabled_writes", 64'(cnt_we[3]), 64'd0);

        // single-shot
        set_win(0, 10, 5, 4, 2);
        single_shot = 1'b1;
        run(FRAME, 0, 0);
        run(FRAME / 2, 0, 0);
        chk("ss_idle_busy", 64'(busy), 64'd0);
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("ss_armed_busy", 64'(busy), 64'd1);
        run(FRAME - FRAME / 2 - 1, 0, 0);
        chk("ss_armed_writes", 64'(cnt_we[0]), 64'd0);
        run(FRAME, 0, 0);
        chk("ss_cap_writes", 64'(cnt_we[0]), 64'd8);
        chk("ss_cap_done", 64'(cnt_fd), 64'd1);
        chk("ss_end_busy", 64'(busy), 64'd0);
        run(FRAME, 0, 0);
        chk("ss_after_writes", 64'(cnt_we[0]), 64'd0);
        run(3 * FRAME, 700, 400);

        // reset in the middle of a capture window
        set_win(0, 10, 5, 4, 2);
        single_shot = 1'b0;
        run(2 * FRAME, 0, 0);
        for (int i = 0; i < 2 * FRAME && !(mh == 12 && mv == 5); i++) step();
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_h", 64'(h_count), 64'd0);
        run(2 * FRAME, 0, 0);

        // random geometry, continuous
        for (int c = 0; c < NUM_CH; c++) rand_win(c);
        run(3 * FRAME, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
